// File: rtl/demux5_pkg.sv
// Shared select codes and decode helper for the 5-way dispatch/collect pair.
// The mux on the collect side uses the same one-hot codes.
package demux5_pkg;

  localparam int NUM_CH = 5;

  localparam logic [3:0] SEL_CH0 = 4'b0001;
  localparam logic [3:0] SEL_CH1 = 4'b0010;
  localparam logic [3:0] SEL_CH2 = 4'b0100;
  localparam logic [3:0] SEL_CH3 = 4'b1000;

  typedef logic [2:0] ch_idx_t;

  localparam ch_idx_t CH_DEFAULT = 3'd4;

  // Exact one-hot codes pick channels 0-3; anything else falls to channel 4.
  function automatic ch_idx_t decode_sel(input logic [3:0] sel);
    case (sel)
      SEL_CH0: decode_sel = 3'd0;
      SEL_CH1: decode_sel = 3'd1;
      SEL_CH2: decode_sel = 3'd2;
      SEL_CH3: decode_sel = 3'd3;
      default: decode_sel = CH_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/demux5_slot.sv
// One-entry holding register for a single output channel.
// Fill and drain in the same cycle keeps the slot full with the new beat.
module demux5_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_i,
  input  logic                  rdy_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  drain;

  assign drain = full_q & rdy_i;

  always_comb begin
    full_d = full_q;
    if (fill_i)     full_d = 1'b1;
    else if (drain) full_d = 1'b0;
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  // NOTE: the payload register is deliberately left out of reset; full_q alone
  // says whether its contents mean anything.
  always_ff @(posedge clk) begin
    if (fill_i) data_q <= din_i;
  end

  assign full_o = full_q;
  assign dout_o = data_q;

endmodule

// File: rtl/demux5_module.sv
// Registered 1-to-5 stream demultiplexer: select decode, ready mux and busy OR
// around five independent one-entry slots.
module demux5_module
  import demux5_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  demux5_in_vld,
  output logic                  demux5_in_rdy,
  input  logic [3:0]            demux5_sel,
  input  logic [DATA_WIDTH-1:0] demux5_din,
  output logic [NUM_CH-1:0]     demux5_out_vld,
  input  logic [NUM_CH-1:0]     demux5_out_rdy,
  output logic [DATA_WIDTH-1:0] demux5_dout0,
  output logic [DATA_WIDTH-1:0] demux5_dout1,
  output logic [DATA_WIDTH-1:0] demux5_dout2,
  output logic [DATA_WIDTH-1:0] demux5_dout3,
  output logic [DATA_WIDTH-1:0] demux5_dout4,
  output logic                  demux5_busy
);

  ch_idx_t               tgt;
  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     fill;
  logic [DATA_WIDTH-1:0] dout [NUM_CH];

  assign tgt = decode_sel(demux5_sel);

  // Ready only looks at the addressed slot, so a stalled channel blocks
  // nothing but beats aimed at it.
  // NOTE: the default before the loop keeps this block from inferring a latch.
  always_comb begin
    demux5_in_rdy = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (tgt == ch_idx_t'(k)) demux5_in_rdy = ~full[k] | demux5_out_rdy[k];
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    assign fill[k] = demux5_in_vld & demux5_in_rdy & (tgt == ch_idx_t'(k));

    demux5_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .fill_i (fill[k]),
      .rdy_i  (demux5_out_rdy[k]),
      .din_i  (demux5_din),
      .full_o (full[k]),
      .dout_o (dout[k])
    );
  end

  assign demux5_out_vld = full;
  assign demux5_busy    = |full;
  assign demux5_dout0   = dout[0];
  assign demux5_dout1   = dout[1];
  assign demux5_dout2   = dout[2];
  assign demux5_dout3   = dout[3];
  assign demux5_dout4   = dout[4];

endmodule
